// File: rtl/mul_seq_arb_if.sv
// Request/grant and product-stream bundle for the round-robin sequential multiplier.
// master drives requests and operands; slave returns grants and products.
interface mul_seq_arb_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) ();
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] d_in;
    logic [N_REQ-1:0]    grant;
    logic                out_valid;
    logic [DW+2:0]       out_data;
    logic [1:0]          out_id;
    logic [1:0]          out_step;
    logic                out_last;
    logic                busy;

    modport master (
        output req, d_in,
        input  grant, out_valid, out_data, out_id, out_step, out_last, busy
    );

    modport slave (
        input  req, d_in,
        output grant, out_valid, out_data, out_id, out_step, out_last, busy
    );
endinterface

// File: rtl/mul_seq_arb.sv
// Four-lane round-robin arbiter feeding a 4-step constant multiplier
// that streams d*1, d*3, d*7, d*8 for the granted lane.
module mul_seq_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_arb_if.slave  bus
);
    localparam int RW = DW + 3;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t           state;
    logic [1:0]       step;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [DW-1:0]    d_reg;
    logic [N_REQ-1:0] grant;
    logic             out_valid;
    logic [RW-1:0]    out_data;
    logic [1:0]       out_id;
    logic [1:0]       out_step;
    logic             out_last;
    logic             busy;

    logic             any_req;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             found;
    logic [N_REQ-1:0] pick_oh;
    logic [DW-1:0]    d_sel;

    function automatic logic [RW-1:0] prod(
        input logic [DW-1:0] d,
        input logic [1:0]    s
    );
        logic [RW-1:0] x;
        x = {3'b000, d};
        unique case (s)
            2'd0:    prod = x;
            2'd1:    prod = (x << 1) + x;
            2'd2:    prod = (x << 3) - x;
            default: prod = x << 3;
        endcase
    endfunction

    assign any_req = |bus.req;

    // Search starts at the priority pointer and wraps around the lanes.
    always_comb begin
        pick  = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
    assign d_sel   = bus.d_in[int'(winner)*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            ptr       <= '0;
            winner    <= '0;
            d_reg     <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_step  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        winner <= pick;
                        grant  <= pick_oh;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Step-0 product comes straight from the live operand.
                    grant     <= '0;
                    d_reg     <= d_sel;
                    ptr       <= winner + 2'd1;
                    step      <= 2'd0;
                    out_valid <= 1'b1;
                    out_data  <= prod(d_sel, 2'd0);
                    out_id    <= winner;
                    out_step  <= 2'd0;
                    out_last  <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (step != 2'd3) begin
                        step     <= step + 2'd1;
                        out_data <= prod(d_reg, step + 2'd1);
                        out_step <= step + 2'd1;
                        out_last <= (step == 2'd2);
                    end else begin
                        step      <= 2'd0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_id    <= '0;
                        out_step  <= '0;
                        out_last  <= 1'b0;
                        if (any_req) begin
                            winner <= pick;
                            grant  <= pick_oh;
                            state  <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_id    = out_id;
    assign bus.out_step  = out_step;
    assign bus.out_last  = out_last;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_mul_seq_arb.sv
// Directed and randomized checks of mul_seq_arb against a
// job-level model: round-robin winner choice and products d*{1,3,7,8}.
module tb_mul_seq_arb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_seq_arb_if #(.N_REQ(4), .DW(8)) bus ();

    mul_seq_arb #(.N_REQ(4), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors = 0;
    int         errors  = 0;
    int         rr_ptr  = 0;
    logic [7:0] dv [4];
    int         mult [4] = '{1, 3, 7, 8};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d();
        bus.d_in = {dv[3], dv[2], dv[1], dv[0]};
    endtask

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(rr_ptr + k) % 4]) return (rr_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_data"},  32'(bus.out_data), 0);
        chk({tag, "_id"},    32'(bus.out_id), 0);
        chk({tag, "_step"},  32'(bus.out_step), 0);
        chk({tag, "_last"},  32'(bus.out_last), 0);
        chk({tag, "_grant"}, 32'(bus.grant), 0);
        chk({tag, "_busy"},  32'(bus.busy), 0);
    endtask

    // One complete job; call while the deciding edge is the next one.
    task automatic job(input bit drop, input int raise_lane,
                       input int raise_step);
        int w;
        int ed;
        w = model_pick(bus.req);
        step();
        ed = int'(dv[w]);
        chk("grant", 32'(bus.grant), 32'(4'b0001 << w));
        chk("load_busy", 32'(bus.busy), 1);
        chk("load_valid", 32'(bus.out_valid), 0);
        rr_ptr = (w + 1) % 4;
        if (drop) bus.req[w] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            chk("valid", 32'(bus.out_valid), 1);
            chk("data", 32'(bus.out_data), 32'(ed * mult[s]));
            chk("id", 32'(bus.out_id), 32'(w));
            chk("step", 32'(bus.out_step), 32'(s));
            chk("last", 32'(bus.out_last), 32'(s == 3));
            chk("run_grant", 32'(bus.grant), 0);
            chk("run_busy", 32'(bus.busy), 1);
            if (drop && s == 0) begin
                dv[w] = 8'($urandom);
                drive_d();
            end
            if (s == raise_step) bus.req[raise_lane] = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
        drive_d();
        step();
        step();
        chk_idle("reset");

        // Single lane-2 job, arbitrated on the first edge after reset.
        rst   = 1'b0;
        dv[2] = 8'd5;
        drive_d();
        bus.req = 4'b0100;
        job(1'b1, -1, -1);
        step();
        chk_idle("after_l2");

        // Full-scale operand, no truncation.
        dv[0] = 8'd255;
        drive_d();
        bus.req = 4'b0001;
        job(1'b1, -1, -1);
        step();
        chk_idle("after_l0");

        // Reset pointer, then all four lanes held.
        rst = 1'b1;
        #1;
        rr_ptr = 0;
        chk_idle("rst_mid");
        step();
        rst = 1'b0;
        dv[0] = 8'd1;
        dv[1] = 8'd2;
        dv[2] = 8'd3;
        dv[3] = 8'd4;
        drive_d();
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) job(1'b0, -1, -1);
        bus.req = 4'b0000;
        step();
        chk_idle("after_rr");

        // Lane 3 arrives during lane 1 step 1: back-to-back.
        bus.req = 4'b0010;
        job(1'b1, 3, 1);
        job(1'b1, -1, -1);
        step();
        chk_idle("after_b2b");

        // Reset in the middle of a job.
        bus.req = 4'b0100;
        step();
        chk("abort_grant", 32'(bus.grant), 32'(4'b0100));
        bus.req = 4'b0000;
        step();
        step();
        chk("abort_step", 32'(bus.out_step), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("abort_async");
        rr_ptr = 0;
        step();
        chk_idle("abort_hold");
        rst = 1'b0;
        bus.req = 4'b1001;
        job(1'b1, -1, -1);
        chk("ptr_after_rst", 32'(rr_ptr), 1);
        job(1'b1, -1, -1);
        step();
        chk_idle("after_abort");

        // Lane 2 drops req in LOAD and its operand changes afterwards.
        dv[2] = 8'd77;
        drive_d();
        bus.req = 4'b0100;
        job(1'b1, -1, -1);
        step();
        chk_idle("after_drop");

        // Random request sets and operands.
        for (int it = 0; it < 8; it++) begin
            int n;
            for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
            drive_d();
            bus.req = 4'($urandom_range(1, 15));
            n = 0;
            while (bus.req != 4'b0000 && n < 4) begin
                job(1'b1, -1, -1);
                n++;
            end
            chk("rand_drained", 32'(bus.req), 0);
            step();
            chk_idle("rand_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule

// File: doc/mul_seq_arb.md
MUL_SEQ_ARB -- requirements
Module: mul_seq_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requester lanes; the arbitration logic SHALL be written for N_REQ=4 (2-bit lane id).
REQ-002 Parameter DW, default 8, operand width; result width SHALL be DW+3 (11 bits at default).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high; SHALL clear all state immediately on assertion.
REQ-005 req  input  N_REQ  per-lane job request, level; the lane SHALL hold it high until its grant bit is seen high.
REQ-006 d_in  input  N_REQ*DW  per-lane operand; lane i occupies bits [i*DW+DW-1 : i*DW], held stable while req[i] is high.
REQ-007 grant  output  N_REQ  registered one-hot grant pulse, one cycle wide, marking the cycle the operand is captured.
REQ-008 out_valid  output  1  registered; high while out_data holds a valid product.
REQ-009 out_data  output  DW+3  registered product, zero-extended.
REQ-010 out_id  output  2  lane id of the job in flight.
REQ-011 out_step  output  2  step index 0..3 of the current product.
REQ-012 out_last  output  1  high with out_valid on step 3 only.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, LOAD, RUN; RUN contains a 2-bit step counter, 0..3.
REQ-015 IDLE: if req is non-zero, SHALL pick a winner round-robin, register it, and go to LOAD; otherwise stay in IDLE.
REQ-016 LOAD (exactly 1 cycle): grant SHALL equal one-hot(winner), d_reg SHALL capture the winner's d_in slice at the end of the cycle, and the next state SHALL be RUN with step 0.
REQ-017 RUN: out_valid SHALL be 1 for 4 consecutive cycles, steps 0,1,2,3, each step advancing by 1 per cycle.
REQ-018 Products: step0 = d_reg, step1 = (d_reg<<1)+d_reg, step2 = (d_reg<<3)-d_reg, step3 = d_reg<<3.
REQ-019 Products SHALL be computed in DW+3 bits with no overflow; maximum value is 2040 at DW=8.
REQ-020 out_id and out_step SHALL be valid with out_valid; out_data, out_id and out_step SHALL be 0 when out_valid is 0.
REQ-021 Latency: req seen in IDLE at cycle T gives grant at T+1 and out_valid at T+2..T+5.
REQ-022 At step 3, if req is non-zero, a winner SHALL be picked that cycle and the next state SHALL be LOAD, giving back-to-back jobs with one job per 5 cycles and no idle gap. Otherwise the next state SHALL be IDLE.
REQ-023 Round-robin pointer: after reset, lane 0 has highest priority.
REQ-024 Round-robin update: after lane i is granted, lane (i+1) mod 4 SHALL have highest priority, and the pointer SHALL update in the LOAD cycle.
REQ-025 Requests arriving during LOAD or RUN steps 0-2 SHALL be ignored until step 3 or IDLE; no request is lost while held.
REQ-026 If the winner's req drops during LOAD, the job SHALL still run on the d_in captured in LOAD.
REQ-027 All four lanes requesting continuously SHALL produce grant order 0,1,2,3,0,... with no starvation.
REQ-028 The grant of a lane SHALL NOT be repeated for the same job; exactly one grant pulse is issued per job.

Reset
REQ-029 On rst high, all of the following SHALL be 0 asynchronously: state=IDLE, step, d_reg, grant, out_valid, out_data, out_id, out_step, out_last, busy; priority pointer SHALL be lane 0.
REQ-030 Reset during LOAD or RUN SHALL discard the job with no further out_valid.
REQ-031 The first arbitration after reset deassertion SHALL occur on the first rising edge with rst low.

Verification
REQ-032 req=4'b0100, lane2 d=5 from IDLE -> grant=4'b0100 at T+1; out_data 5,15,35,40 at T+2..T+5; out_id=2; out_last at T+5.
REQ-033 Lane0 d=255 -> out_data 255,765,1785,2040; no truncation.
REQ-034 req=4'b1111 held, d=1,2,3,4 -> grants to lanes 0,1,2,3 spaced 5 cycles apart; busy stays high throughout; products correct per lane.
REQ-035 Lane1 running, lane3 raises req at step 1 -> lane3 grant in the cycle after lane1's step 3; no IDLE cycle between jobs.
REQ-036 rst pulsed during step 1 -> all outputs 0 immediately; then req=4'b1001 -> lane 0 is granted first, confirming the pointer was reset.
REQ-037 Lane2 drops req during its LOAD cycle -> job completes with the captured d; exactly one grant pulse is observed.
